mem_copy_dma: RTL and testbench

Initiator-side word-copy engine that drives the single-port `ram` interface: `addr`, `data`, `MemWrite`, `MemRead`. It copies a block of words from a source address to a destination address by alternating read and write cycles. It also accumulates a modular checksum of the words it moves. It sits between the control path and the data RAM, and is the only master on the RAM port while `o_busy` is high.

---
 rtl/mem_copy_dma.sv | 164 ++++++++++++++++
 tb/tb_mem_copy_dma.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma
// Word-copy engine that masters a single-port RAM. It reads one word, then writes it,
// in ascending order from src/dst. It also keeps a running sum of every word it reads.
//
// Ports
//   i_clk, i_rst      : clock and synchronous active-high reset
//   i_start           : transfer request, sampled only while idle
//   i_src, i_dst      : source / destination start word addresses
//   i_len             : number of words to copy (0 completes immediately)
//   o_busy            : high in every state except IDLE
//   o_done            : one-cycle completion pulse
//   o_sum             : sum of all words read, modulo 2^DATA_WIDTH
//   o_addr, o_data    : RAM address and write data
//   o_MemWrite        : RAM write strobe
//   o_MemRead         : RAM read strobe
//   i_data            : RAM read data (combinational)
module mem_copy_dma #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_src,
    input  logic [ADDR_WIDTH-1:0] i_dst,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_MemWrite,
    output logic                  o_MemRead,
    input  logic [DATA_WIDTH-1:0] i_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    // Every output is a flop loaded from the next-state decode, so the RAM
    // port sees clean, glitch-free levels for the whole cycle.
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;

    logic [ADDR_WIDTH-1:0] cnt_ext_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    sum_d = '0;
                    if (i_len != '0) begin
                        src_d   = i_src;
                        dst_d   = i_dst;
                        len_d   = i_len;
                        cnt_d   = '0;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                buf_d   = i_data;
                sum_d   = sum_q + i_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cnt_d   = cnt_q + LEN_WIDTH'(1);
                state_d = (cnt_d == len_q) ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered; the address uses the
    // updated counter so READ after WRITE already points at the next word.
    always_comb begin
        cnt_ext_d = ADDR_WIDTH'(cnt_d);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rd_d      = (state_d == S_READ);
        wr_d      = (state_d == S_WRITE);
        addr_d    = '0;
        data_d    = '0;
        if (state_d == S_READ) begin
            addr_d = src_d + cnt_ext_d;
        end else if (state_d == S_WRITE) begin
            addr_d = dst_d + cnt_ext_d;
            data_d = buf_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_sum      = sum_q;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_MemWrite = wr_q;
    assign o_MemRead  = rd_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: a 256-word RAM model, a cycle-plan
// reference model producing expected per-cycle port values, and a monitor.
module tb_mem_copy_dma;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src, dst;
    logic [5:0]  len;
    logic        busy, done;
    logic [31:0] sum, addr, wdata, rdata;
    logic        mem_we, mem_re;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    typedef struct packed {
        logic        busy;
        logic        rd;
        logic        wr;
        logic        done;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] sum;
        logic        cmp_addr;
        logic        cmp_data;
    } exp_t;

    exp_t exp_q[$];

    mem_copy_dma #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_src(src), .i_dst(dst),
        .i_len(len), .o_busy(busy), .o_done(done), .o_sum(sum), .o_addr(addr),
        .o_data(wdata), .o_MemWrite(mem_we), .o_MemRead(mem_re), .i_data(rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge, both strobes -> ignored
    assign rdata = mem[addr[7:0]];
    always @(posedge clk) begin
        if (mem_we && !mem_re) mem[addr[7:0]] <= wdata;
    end

    // Monitor: one expected record per cycle; an empty queue means idle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{busy:0, rd:0, wr:0, done:0, addr:0, data:0, sum:0, cmp_addr:1, cmp_data:1};
            checks++;
            if (mem_re && mem_we) begin
                errors++;
                $display("FAIL strobe_overlap t=%0t rd=%0b wr=%0b required not both", $time, mem_re, mem_we);
            end
            checks++;
            if ({busy, mem_re, mem_we, done} !== {e.busy, e.rd, e.wr, e.done}) begin
                errors++;
                $display("FAIL ctrl t=%0t busy/rd/wr/done got %b required %b", $time,
                         {busy, mem_re, mem_we, done}, {e.busy, e.rd, e.wr, e.done});
            end
            if (e.cmp_addr) begin
                checks++;
                if (addr !== e.addr) begin
                    errors++;
                    $display("FAIL addr t=%0t got %h required %h", $time, addr, e.addr);
                end
            end
            if (e.cmp_data) begin
                checks++;
                if (wdata !== e.data) begin
                    errors++;
                    $display("FAIL wdata t=%0t got %h required %h", $time, wdata, e.data);
                end
            end
            if (e.done) begin
                checks++;
                if (sum !== e.sum) begin
                    errors++;
                    $display("FAIL done_sum t=%0t got %h required %h", $time, sum, e.sum);
                end
            end
        end
    end

    task automatic preset(input int mode);
        for (int k = 0; k < 256; k++) begin
            logic [31:0] v;
            v = (mode == 0) ? 32'(k + 1) : $urandom;
            mem[k] = v;
            ref_mem[k] = v;
        end
    endtask

    task automatic set_word(input int k, input logic [31:0] v);
        mem[k] = v;
        ref_mem[k] = v;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        int first = -1;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== ref_mem[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_%s %0d words differ, first at %0d got %h required %h",
                     tag, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    // Transfer driver. The model plans the cycle-by-cycle port values of a
    // word-by-word ascending copy. Cycles beyond 'limit' are cut off by a reset.
    // 'poke' pulses i_start with other arguments in cycle 2 and in the DONE cycle.
    task automatic xfer(input logic [31:0] s, input logic [31:0] d, input logic [5:0] n,
                        input int limit, input bit poke, input string tag);
        exp_t recs[$];
        logic [31:0] msum = 0;
        logic [31:0] a, r;
        int c = 1;
        int total;
        total = (n == 0) ? 1 : 2 * int'(n) + 1;
        for (int i = 0; i < int'(n); i++) begin
            a = s + 32'(i);
            r = ref_mem[a[7:0]];
            if (c <= limit)
                recs.push_back('{busy:1, rd:1, wr:0, done:0, addr:a, data:0, sum:0, cmp_addr:1, cmp_data:0});
            c++;
            msum = msum + r;
            a = d + 32'(i);
            if (c <= limit) begin
                recs.push_back('{busy:1, rd:0, wr:1, done:0, addr:a, data:r, sum:0, cmp_addr:1, cmp_data:1});
                ref_mem[a[7:0]] = r;
            end
            c++;
        end
        if (c <= limit)
            recs.push_back('{busy:1, rd:0, wr:0, done:1, addr:0, data:0, sum:msum, cmp_addr:0, cmp_data:0});
        if (limit < total) msum = 0;

        @(posedge clk); #1;
        start = 1; src = s; dst = d; len = n;
        @(posedge clk); #1;      // acceptance edge passed, now in cycle 1
        start = 0; src = $urandom; dst = $urandom; len = 6'($urandom);
        foreach (recs[i]) exp_q.push_back(recs[i]);

        if (poke) begin
            @(posedge clk); #1;  // cycle 2
            start = 1; src = 32'd100; dst = 32'd200; len = 6'd5;
            @(posedge clk); #1;  // cycle 3
            start = 0;
            repeat (total - 3) @(posedge clk);
            #1;                  // DONE cycle
            start = 1; src = 32'd120; dst = 32'd210; len = 6'd3;
            @(posedge clk); #1;
            start = 0;
        end

        if (limit < total) begin
            repeat (limit - 1) @(posedge clk);
            #1;
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
        end

        begin
            int guard = 0;
            while (exp_q.size() > 0 && guard < 300) begin
                @(posedge clk);
                guard++;
            end
            checks++;
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL timeout_%s %0d expected cycles left, required 0", tag, exp_q.size());
                exp_q.delete();
            end
        end
        @(posedge clk); #1;
        check_mem(tag);
        checks++;
        if (sum !== msum) begin
            errors++;
            $display("FAIL sum_hold_%s got %h required %h", tag, sum, msum);
        end
    endtask

    initial begin
        rst = 1; start = 0; src = 0; dst = 0; len = 0;
        preset(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        checks++;
        if ({busy, done, mem_re, mem_we} !== 4'b0 || sum !== 0 || addr !== 0 || wdata !== 0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b rd=%b wr=%b sum=%h addr=%h data=%h required all 0",
                     busy, done, mem_re, mem_we, sum, addr, wdata);
        end
        mon_en = 1;

        preset(0);
        xfer(32'd0, 32'd16, 6'd4, 1000, 0, "basic");
        xfer(32'd5, 32'd9, 6'd0, 1000, 0, "len0");

        preset(0);
        xfer(32'd0, 32'd1, 6'd3, 1000, 0, "overlap");

        preset(0);
        set_word(0, 32'hFFFF_FFFF);
        set_word(1, 32'd2);
        xfer(32'd0, 32'd8, 6'd2, 1000, 0, "sumwrap");

        preset(0);
        xfer(32'd0, 32'd32, 6'd4, 4, 0, "midreset");
        checks++;
        if (busy !== 1'b0 || addr !== 0) begin
            errors++;
            $display("FAIL after_reset busy=%b addr=%h required 0 0", busy, addr);
        end

        preset(1);
        xfer(32'd40, 32'd80, 6'd4, 1000, 1, "ignstart");

        preset(1);
        xfer(32'hFFFF_FFFE, 32'd64, 6'd4, 1000, 0, "addrwrap");

        for (int t = 0; t < 10; t++) begin
            preset(1);
            xfer(32'($urandom_range(0, 150)), 32'($urandom_range(0, 150)),
                 6'($urandom_range(0, 40)), 1000, 0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
